mux_tree_pipe: RTL and testbench

- Parametrised N_IN:1 selector built as a log2(N_IN)-level tree of 2:1 mux stages, with an optional register after each level.
- Successor to the fixed 8:1 combinational tree. Adds:
  - generic data width and input count;
  - a valid pipeline;
  - an auto-scan mode, in which an internal counter steps the select across all inputs.
- Sits between multi-channel sample sources and a single downstream consumer.

---
 rtl/mux_tree_pkg.sv | 15 +
 rtl/mux_tree_pipe_mux2_stage.sv | 71 +++++++
 rtl/mux_tree_pipe.sv | 89 ++++++++
 tb/tb_mux_tree_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pkg.sv
// Shared definitions for the pipelined mux tree: mode encodings and tree sizing.
package mux_tree_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Number of 2:1 levels needed to reduce n inputs to one.
  function automatic int tree_levels(input int n);
    int levels;
    levels = 0;
    while ((1 << levels) < n) levels++;
    return levels;
  endfunction

endpackage

// File: rtl/mux_tree_pipe_mux2_stage.sv
// One level of the selector tree: N_PAIRS 2:1 muxes steered by select bit LEVEL,
// optionally followed by a register stage carrying data, the full select and valid.
module mux2_stage #(
  parameter int WIDTH   = 1,
  parameter int N_PAIRS = 1,
  parameter int SEL_W   = 1,
  parameter int LEVEL   = 0,
  parameter int REG     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2*N_PAIRS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]           sel_in,
  input  logic                       valid_in,
  output logic [N_PAIRS*WIDTH-1:0]   data_out,
  output logic [SEL_W-1:0]           sel_out,
  output logic                       valid_out
);

  logic [N_PAIRS*WIDTH-1:0] mux_d;

  // Pair j picks element 2j+1 when this level's select bit is set, else 2j.
  always_comb begin
    // NOTE: assign a default before the loop so every bit is driven on every path; no latch is inferred.
    mux_d = '0;
    for (int j = 0; j < N_PAIRS; j++) begin
      mux_d[j*WIDTH +: WIDTH] = sel_in[LEVEL] ? data_in[(2*j+1)*WIDTH +: WIDTH]
                                              : data_in[(2*j)*WIDTH +: WIDTH];
    end
  end

  if (REG != 0) begin : g_reg
    logic [N_PAIRS*WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic                     valid_q, valid_d;

    // Data and select only advance on valid samples; bubbles just clear valid.
    always_comb begin
      data_d  = valid_in ? mux_d : data_q;
      sel_d   = valid_in ? sel_in : sel_q;
      valid_d = valid_in;
    end

    // Stage register with asynchronous clear of everything, data included.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: data registers are reset as well because `out` must read 0 until the first valid sample emerges.
        data_q  <= '0;
        sel_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every stage samples the previous stage's old value on the same edge.
        data_q  <= data_d;
        sel_q   <= sel_d;
        valid_q <= valid_d;
      end
    end

    assign data_out  = data_q;
    assign sel_out   = sel_q;
    assign valid_out = valid_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign data_out  = mux_d;
    assign sel_out   = sel_in;
    assign valid_out = valid_in;
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// N_IN:1 selector built from SEL_W levels of 2:1 muxes, with a valid pipeline
// and an auto-scan mode that steps the select across all channels.
module mux_tree_pipe
  import mux_tree_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N_IN  = 8,
  parameter int SEL_W = tree_levels(N_IN),
  parameter int PIPE  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      out,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid
);

  if (N_IN < 2 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
    $error("mux_tree_pipe: N_IN must be a power of two and at least 2");
  end

  logic [SEL_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [SEL_W-1:0] eff_sel;

  // Scan counter: cleared in direct mode, steps per accepted sample in scan mode.
  // N_IN is a power of two, so natural overflow gives the N_IN-1 -> 0 wrap.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    if (mode == MODE_DIRECT) scan_cnt_d = '0;
    else if (in_valid)       scan_cnt_d = scan_cnt_q + SEL_W'(1);
    eff_sel = (mode == MODE_SCAN) ? scan_cnt_q : sel;
  end

  // Scan counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_cnt_q <= '0;
    else        scan_cnt_q <= scan_cnt_d;
  end

  // Level k halves the candidate set using select bit k (LSB first, so out = in[eff_sel]).
  // Without PIPE only the last level is registered, giving a single output register.
  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int N_PAIRS   = N_IN >> (k + 1);
    localparam int STAGE_REG = (PIPE != 0 || k == SEL_W - 1) ? 1 : 0;

    logic [2*N_PAIRS*WIDTH-1:0] d_in;
    logic [SEL_W-1:0]           s_in;
    logic                       v_in;
    logic [N_PAIRS*WIDTH-1:0]   d_out;
    logic [SEL_W-1:0]           s_out;
    logic                       v_out;

    if (k == 0) begin : g_first
      assign d_in = in;
      assign s_in = eff_sel;
      assign v_in = in_valid;
    end else begin : g_next
      assign d_in = g_lvl[k-1].d_out;
      assign s_in = g_lvl[k-1].s_out;
      assign v_in = g_lvl[k-1].v_out;
    end

    mux2_stage #(
      .WIDTH  (WIDTH),
      .N_PAIRS(N_PAIRS),
      .SEL_W  (SEL_W),
      .LEVEL  (k),
      .REG    (STAGE_REG)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (d_in),
      .sel_in   (s_in),
      .valid_in (v_in),
      .data_out (d_out),
      .sel_out  (s_out),
      .valid_out(v_out)
    );
  end

  assign out       = g_lvl[SEL_W-1].d_out;
  assign out_sel   = g_lvl[SEL_W-1].s_out;
  assign out_valid = g_lvl[SEL_W-1].v_out;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe. Three instances share clock and reset:
//   u_a: WIDTH=1, N_IN=8, PIPE=1 (latency 3)
//   u_b: WIDTH=1, N_IN=8, PIPE=0 (latency 1), same inputs as u_a
//   u_c: WIDTH=8, N_IN=4, PIPE=1 (latency 2)
// Each instance has a queue of expected results, one entry per cycle, pre-filled with
// latency-many entries so the popped entry lines up with the sample now at the output.
module tb_mux_tree_pipe;

  typedef struct packed {
    logic       v;     // out_valid expected
    logic       zero;  // when not valid: out and out_sel must still be 0 (nothing since reset)
    logic [7:0] d;
    logic [2:0] s;
  } exp_t;

  typedef struct packed {
    logic [7:0] din;
    logic [2:0] sel;
    logic       mode;
    logic       valid;
    logic       xv;
    logic       xd;
    logic [2:0] xs;
  } vec_t;

  logic clk;
  logic rst_n;

  logic [7:0]  ab_in;
  logic [2:0]  ab_sel;
  logic        ab_mode;
  logic        ab_valid;
  logic        a_out, b_out;
  logic [2:0]  a_out_sel, b_out_sel;
  logic        a_out_valid, b_out_valid;

  logic [31:0] c_in;
  logic [1:0]  c_sel;
  logic        c_mode;
  logic        c_valid;
  logic [7:0]  c_out;
  logic [1:0]  c_out_sel;
  logic        c_out_valid;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int scan_ab = 0;
  int scan_c  = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  vec_t vecs[$];

  mux_tree_pipe #(.WIDTH(1), .N_IN(8), .PIPE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in(ab_in), .sel(ab_sel), .mode(ab_mode), .in_valid(ab_valid),
    .out(a_out), .out_sel(a_out_sel), .out_valid(a_out_valid)
  );

  mux_tree_pipe #(.WIDTH(1), .N_IN(8), .PIPE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in(ab_in), .sel(ab_sel), .mode(ab_mode), .in_valid(ab_valid),
    .out(b_out), .out_sel(b_out_sel), .out_valid(b_out_valid)
  );

  mux_tree_pipe #(.WIDTH(8), .N_IN(4), .PIPE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in(c_in), .sel(c_sel), .mode(c_mode), .in_valid(c_valid),
    .out(c_out), .out_sel(c_out_sel), .out_valid(c_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic v, input logic zero, input logic [7:0] d,
                                  input logic [2:0] s);
    exp_t e;
    e.v = v; e.zero = zero; e.d = d; e.s = s;
    return e;
  endfunction

  // Reference for the 8x1-bit instances: pick channel eff of the input word.
  function automatic exp_t model_ab(input logic [7:0] din, input logic [2:0] sel,
                                    input logic mode, input logic valid);
    int eff;
    eff = mode ? scan_ab : int'(sel);
    return mk_exp(valid, 1'b0, {7'd0, din[eff]}, 3'(eff));
  endfunction

  // Reference for the 4x8-bit instance.
  function automatic exp_t model_c(input logic [31:0] din, input logic [1:0] sel,
                                   input logic mode, input logic valid);
    int eff;
    eff = mode ? scan_c : int'(sel);
    return mk_exp(valid, 1'b0, din[eff*8 +: 8], 3'(eff));
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic v, input logic [7:0] d,
                         input logic [2:0] s);
    check({tag, ".out_valid"}, {31'd0, v}, {31'd0, e.v});
    if (e.v) begin
      check({tag, ".out"}, {24'd0, d}, {24'd0, e.d});
      check({tag, ".out_sel"}, {29'd0, s}, {29'd0, e.s});
    end else if (e.zero) begin
      check({tag, ".out_idle"}, {24'd0, d}, 32'd0);
      check({tag, ".out_sel_idle"}, {29'd0, s}, 32'd0);
    end
  endtask

  task automatic prefill();
    qa.delete(); qb.delete(); qc.delete();
    repeat (3) qa.push_back(mk_exp(1'b0, 1'b1, 8'd0, 3'd0));
    qb.push_back(mk_exp(1'b0, 1'b1, 8'd0, 3'd0));
    repeat (2) qc.push_back(mk_exp(1'b0, 1'b1, 8'd0, 3'd0));
    scan_ab = 0;
    scan_c  = 0;
  endtask

  // One clock cycle: check what is at the outputs now, then drive the next sample.
  task automatic cycle(input logic [7:0] a_din, input logic [2:0] a_sel, input logic a_mode,
                       input logic a_vld, input exp_t a_exp,
                       input logic [31:0] c_din, input logic [1:0] c_s, input logic c_m,
                       input logic c_vld, input exp_t c_exp);
    @(negedge clk);
    cyc++;
    if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
      check("queue_underflow", 32'd1, 32'd0);
    end else begin
      compare("a", qa.pop_front(), a_out_valid, {7'd0, a_out}, a_out_sel);
      compare("b", qb.pop_front(), b_out_valid, {7'd0, b_out}, b_out_sel);
      compare("c", qc.pop_front(), c_out_valid, c_out, {1'b0, c_out_sel});
    end
    ab_in = a_din; ab_sel = a_sel; ab_mode = a_mode; ab_valid = a_vld;
    c_in = c_din;  c_sel = c_s;    c_mode = c_m;     c_valid = c_vld;
    qa.push_back(a_exp);
    qb.push_back(a_exp);
    qc.push_back(c_exp);
    if (!a_mode) scan_ab = 0; else if (a_vld) scan_ab = (scan_ab + 1) % 8;
    if (!c_m)    scan_c  = 0; else if (c_vld) scan_c  = (scan_c + 1) % 4;
  endtask

  task automatic add_vec(input logic [7:0] din, input logic [2:0] sel, input logic mode,
                         input logic valid, input logic xv, input logic xd, input logic [2:0] xs);
    vec_t v;
    v.din = din; v.sel = sel; v.mode = mode; v.valid = valid;
    v.xv = xv; v.xd = xd; v.xs = xs;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a_valid"}, {31'd0, a_out_valid}, 32'd0);
    check({tag, ".a_out"},   {31'd0, a_out}, 32'd0);
    check({tag, ".a_sel"},   {29'd0, a_out_sel}, 32'd0);
    check({tag, ".b_valid"}, {31'd0, b_out_valid}, 32'd0);
    check({tag, ".c_valid"}, {31'd0, c_out_valid}, 32'd0);
    check({tag, ".c_out"},   {24'd0, c_out}, 32'd0);
  endtask

  initial begin
    exp_t ea, ec, none, idle0;
    logic [7:0]  r_in;
    logic [2:0]  r_sel;
    logic [31:0] r_cin;
    logic [1:0]  r_csel;
    logic        r_mode, r_cmode, r_v, r_cv;

    none  = mk_exp(1'b0, 1'b0, 8'd0, 3'd0);
    idle0 = mk_exp(1'b0, 1'b1, 8'd0, 3'd0);

    // Direct select over two input patterns.
    for (int i = 0; i < 8; i++) add_vec(8'b1010_1010, 3'(i), 1'b0, 1'b1, 1'b1, i[0], 3'(i));
    for (int i = 0; i < 8; i++) add_vec(8'b1111_0000, 3'(i), 1'b0, 1'b1, 1'b1, (i >= 4), 3'(i));
    // Auto-scan: sel input is ignored, channels stepped 0..7 then wrap.
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1);
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3);
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5);
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6);
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    add_vec(8'hCA, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1);
    // Back to direct for one sample, then scan restarts at channel 0.
    add_vec(8'hCA, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3);
    add_vec(8'hCA, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    add_vec(8'hCA, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1);
    // Bubbles in direct mode.
    add_vec(8'hA5, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5);
    add_vec(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    add_vec(8'hA5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2);
    add_vec(8'hA5, 3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7);
    add_vec(8'hA5, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    rst_n = 1'b0;
    ab_in = '0; ab_sel = '0; ab_mode = 1'b0; ab_valid = 1'b0;
    c_in = '0;  c_sel = '0;  c_mode = 1'b0;  c_valid = 1'b0;
    #3;
    check_all_zero("in_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prefill();

    // Table-driven vectors on the 8x1 instances; wide instance idle since reset.
    foreach (vecs[i]) begin
      ea = mk_exp(vecs[i].xv, 1'b0, {7'd0, vecs[i].xd}, vecs[i].xs);
      cycle(vecs[i].din, vecs[i].sel, vecs[i].mode, vecs[i].valid, ea,
            32'd0, 2'd0, 1'b0, 1'b0, idle0);
    end

    // Wide data: capture channel 2, then change the input the very next cycle.
    cycle(8'd0, 3'd0, 1'b0, 1'b0, none, 32'h4433_2211, 2'd2, 1'b0, 1'b1,
          mk_exp(1'b1, 1'b0, 8'h33, 3'd2));
    cycle(8'd0, 3'd0, 1'b0, 1'b0, none, 32'hDEAD_BEEF, 2'd1, 1'b0, 1'b0, none);
    repeat (3) cycle(8'd0, 3'd0, 1'b0, 1'b0, none, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, none);

    // Randomized traffic against the reference model.
    r_mode = 1'b0; r_cmode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) r_mode  = ~r_mode;
      if ($urandom_range(0, 7) == 0) r_cmode = ~r_cmode;
      r_in   = 8'($urandom);
      r_sel  = 3'($urandom);
      r_v    = ($urandom_range(0, 3) != 0);
      r_cin  = $urandom;
      r_csel = 2'($urandom);
      r_cv   = ($urandom_range(0, 3) != 0);
      ea = model_ab(r_in, r_sel, r_mode, r_v);
      ec = model_c(r_cin, r_csel, r_cmode, r_cv);
      cycle(r_in, r_sel, r_mode, r_v, ea, r_cin, r_csel, r_cmode, r_cv, ec);
    end

    // Reset with samples in flight: advance the scan counters, then reset mid-pipeline.
    for (int i = 0; i < 2; i++) begin
      ea = model_ab(8'hCA, 3'd0, 1'b1, 1'b1);
      ec = model_c(32'h4433_2211, 2'd0, 1'b1, 1'b1);
      cycle(8'hCA, 3'd0, 1'b1, 1'b1, ea, 32'h4433_2211, 2'd0, 1'b1, 1'b1, ec);
    end
    @(posedge clk);
    #2;
    ab_valid = 1'b0;
    c_valid  = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    prefill();

    // After release, scan restarts at channel 0 and only new samples come out.
    cycle(8'hCA, 3'd0, 1'b1, 1'b1, mk_exp(1'b1, 1'b0, 8'd0, 3'd0),
          32'h4433_2211, 2'd0, 1'b1, 1'b1, mk_exp(1'b1, 1'b0, 8'h11, 3'd0));
    cycle(8'hCA, 3'd0, 1'b1, 1'b1, mk_exp(1'b1, 1'b0, 8'd1, 3'd1),
          32'h4433_2211, 2'd0, 1'b1, 1'b1, mk_exp(1'b1, 1'b0, 8'h22, 3'd1));
    repeat (4) cycle(8'd0, 3'd0, 1'b0, 1'b0, none, 32'd0, 2'd0, 1'b0, 1'b0, none);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
